// File: rtl/gpr_access_ctrl.sv
// rtl/gpr_access_ctrl.sv - round-robin sequencer for a 1R1W general-purpose register file
//
// Two requesters issue either a single-register write or a three-operand
// read-sum. One command is in flight at a time. Reads use the single
// combinational read port over three cycles and return the sum in one pulse.
//
// Ports:
//   clk, rst_n                  clock (rising edge), asynchronous active-low reset
//   reqN_valid/ready            command handshake for requester N (0, 1)
//   reqN_wr                     1 = write, 0 = read-sum
//   reqN_addr                   write: index in low REG_W bits;
//                               read: A in top REG_W bits, then B, then C
//   reqN_wdata                  write data
//   rsp_valid/rsp_id/rsp_data   one-cycle read-sum result, issuer id, sum
//   rf_raddr/rf_rdata           register file read port (rdata combinational)
//   rf_we/rf_waddr/rf_wdata     register file write port
//   busy                        a command is being executed

module gpr_access_ctrl #(
    parameter int DATA_W = 14,
    parameter int ADDR_W = 12,
    parameter int REG_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_wr,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_wr,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic [REG_W-1:0]  rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              rf_we,
    output logic [REG_W-1:0]  rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD_A,
        S_RD_B,
        S_RD_C,
        S_RESP
    } state_t;

    state_t state;
    state_t state_nxt;

    logic              cmd_wr;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              cmd_id;
    logic              last_grant;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_id_q;
    logic [REG_W-1:0]  raddr_q;

    logic              idle;
    logic              any_valid;
    logic              grant_id;
    logic              hs;
    logic              hs_wr;
    logic [ADDR_W-1:0] hs_addr;
    logic [DATA_W-1:0] hs_wdata;

    logic [REG_W-1:0]  idx_a;
    logic [REG_W-1:0]  idx_b;
    logic [REG_W-1:0]  idx_c;

    assign idx_a = cmd_addr[ADDR_W-1         -: REG_W];
    assign idx_b = cmd_addr[ADDR_W-REG_W-1   -: REG_W];
    assign idx_c = cmd_addr[ADDR_W-2*REG_W-1 -: REG_W];

    // Round-robin: on contention the requester that did not win last time
    // gets the grant; otherwise the single valid requester wins.
    assign idle       = (state == S_IDLE);
    assign any_valid  = req0_valid | req1_valid;
    assign grant_id   = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
    assign hs         = idle & any_valid;
    assign req0_ready = hs & ~grant_id;
    assign req1_ready = hs &  grant_id;

    assign hs_wr    = grant_id ? req1_wr    : req0_wr;
    assign hs_addr  = grant_id ? req1_addr  : req0_addr;
    assign hs_wdata = grant_id ? req1_wdata : req0_wdata;

    assign busy      = ~idle;
    assign rf_we     = (state == S_WR);
    assign rf_waddr  = cmd_addr[REG_W-1:0];
    assign rf_wdata  = cmd_wdata;
    assign rsp_valid = (state == S_RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;

    always_comb begin
        state_nxt = state;
        rf_raddr  = raddr_q;
        case (state)
            S_IDLE: begin
                if (hs) begin
                    state_nxt = hs_wr ? S_WR : S_RD_A;
                end
            end
            S_WR:   state_nxt = S_IDLE;
            S_RD_A: begin
                rf_raddr  = idx_a;
                state_nxt = S_RD_B;
            end
            S_RD_B: begin
                rf_raddr  = idx_b;
                state_nxt = S_RD_C;
            end
            S_RD_C: begin
                rf_raddr  = idx_c;
                state_nxt = S_RESP;
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cmd_wr     <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            cmd_id     <= 1'b0;
            last_grant <= 1'b1;
            acc        <= '0;
            rsp_data_q <= '0;
            rsp_id_q   <= 1'b0;
            raddr_q    <= '0;
        end else begin
            state   <= state_nxt;
            // Outside the read states rf_raddr already shows raddr_q, so this
            // only changes the held index while reading.
            raddr_q <= rf_raddr;
            case (state)
                S_IDLE: begin
                    if (hs) begin
                        cmd_wr     <= hs_wr;
                        cmd_addr   <= hs_addr;
                        cmd_wdata  <= hs_wdata;
                        cmd_id     <= grant_id;
                        last_grant <= grant_id;
                    end
                end
                S_RD_A: acc <= rf_rdata;
                S_RD_B: acc <= acc + rf_rdata;
                S_RD_C: begin
                    // The response registers are loaded here so the result is
                    // presented during RESP and then held until the next read.
                    acc        <= acc + rf_rdata;
                    rsp_data_q <= acc + rf_rdata;
                    rsp_id_q   <= cmd_id;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gpr_access_ctrl.sv
// tb/tb_gpr_access_ctrl.sv - self-checking bench for gpr_access_ctrl
module tb_gpr_access_ctrl;

    logic        clk;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req0_wr = 1'b0;
    logic [11:0] req0_addr = '0;
    logic [13:0] req0_wdata = '0;
    logic        req1_valid = 1'b0, req1_wr = 1'b0;
    logic [11:0] req1_addr = '0;
    logic [13:0] req1_wdata = '0;
    logic        req0_ready, req1_ready;
    logic        rsp_valid, rsp_id;
    logic [13:0] rsp_data;
    logic [3:0]  rf_raddr;
    logic [13:0] rf_rdata;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [13:0] rf_wdata;
    logic        busy;

    logic [13:0] mem [16];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    int          rq_data[$];
    int          rq_id[$];

    gpr_access_ctrl #(.DATA_W(14), .ADDR_W(12), .REG_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_wr(req0_wr),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_wr(req1_wr),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .busy(busy)
    );

    assign rf_rdata = mem[rf_raddr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
        if (rf_we) mem[rf_waddr] <= rf_wdata;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural model: a command accepted at cycle T occupies the block
    // for 2 cycles (write) or 5 cycles (read); effects are timed from T.
    initial begin
        int  m_rf[16];
        int  m_free_at, m_wr_at, m_rd_at, m_sum, m_rsp_data;
        logic [3:0]  m_wa, m_ia, m_ib, m_ic, m_raddr;
        logic [13:0] m_wd;
        logic m_id, m_last, m_rsp_id;
        logic e_r0, e_r1, e_we, e_rv, g;
        logic [11:0] a;
        for (int i = 0; i < 16; i++) m_rf[i] = 0;
        m_free_at = 0; m_wr_at = -100; m_rd_at = -100; m_sum = 0;
        m_rsp_data = 0; m_rsp_id = 0; m_raddr = 0; m_last = 1;
        m_wa = 0; m_wd = 0; m_ia = 0; m_ib = 0; m_ic = 0; m_id = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_free_at = 0; m_wr_at = -100; m_rd_at = -100;
                m_rsp_data = 0; m_rsp_id = 0; m_raddr = 0; m_last = 1;
            end else begin
                g    = (req0_valid && req1_valid) ? ~m_last : req1_valid;
                e_r0 = (cyc >= m_free_at) && (req0_valid || req1_valid) && !g;
                e_r1 = (cyc >= m_free_at) && (req0_valid || req1_valid) &&  g;
                e_we = (cyc == m_wr_at);
                e_rv = (cyc == m_rd_at + 4);
                if (cyc == m_rd_at + 1) m_raddr = m_ia;
                if (cyc == m_rd_at + 2) m_raddr = m_ib;
                if (cyc == m_rd_at + 3) m_raddr = m_ic;
                if (e_rv) begin
                    m_rsp_data = m_sum;
                    m_rsp_id   = m_id;
                end
                chk("req0_ready", 32'(req0_ready), 32'(e_r0));
                chk("req1_ready", 32'(req1_ready), 32'(e_r1));
                chk("ready_excl", 32'(req0_ready & req1_ready), 32'(0));
                chk("busy", 32'(busy), 32'(cyc < m_free_at));
                chk("rf_we", 32'(rf_we), 32'(e_we));
                if (e_we) begin
                    chk("rf_waddr", 32'(rf_waddr), 32'(m_wa));
                    chk("rf_wdata", 32'(rf_wdata), 32'(m_wd));
                end
                chk("rf_raddr", 32'(rf_raddr), 32'(m_raddr));
                chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
                chk("rsp_data", 32'(rsp_data), 32'(m_rsp_data));
                chk("rsp_id", 32'(rsp_id), 32'(m_rsp_id));
                if (rsp_valid) begin
                    rq_data.push_back(int'(rsp_data));
                    rq_id.push_back(int'(rsp_id));
                end
                if (e_r0 || e_r1) begin
                    m_last = g;
                    a = g ? req1_addr : req0_addr;
                    if (g ? req1_wr : req0_wr) begin
                        m_wa = a[3:0];
                        m_wd = g ? req1_wdata : req0_wdata;
                        m_rf[m_wa] = int'(m_wd);
                        m_wr_at = cyc + 1;
                        m_free_at = cyc + 2;
                    end else begin
                        m_ia = a[11:8]; m_ib = a[7:4]; m_ic = a[3:0];
                        m_sum = (m_rf[m_ia] + m_rf[m_ib] + m_rf[m_ic]) % 16384;
                        m_id = g;
                        m_rd_at = cyc;
                        m_free_at = cyc + 5;
                    end
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that ends
    // the handshake cycle (or the wait budget), with valid dropped.
    task automatic send(input int r, input bit wr, input logic [11:0] a,
                        input logic [13:0] d, input int max_wait,
                        output bit got, output int hc);
        got = 0;
        hc  = -1;
        if (r == 0) begin
            req0_wr = wr; req0_addr = a; req0_wdata = d; req0_valid = 1'b1;
        end else begin
            req1_wr = wr; req1_addr = a; req1_wdata = d; req1_valid = 1'b1;
        end
        for (int k = 0; k < max_wait && !got; k++) begin
            @(negedge clk);
            if (rst_n && ((r == 0) ? req0_ready : req1_ready)) begin
                got = 1;
                hc  = cyc;
            end
        end
        @(posedge clk);
        #1;
        if (r == 0) req0_valid = 1'b0;
        else        req1_valid = 1'b0;
    endtask

    task automatic dsend(input int r, input bit wr, input logic [11:0] a,
                         input logic [13:0] d, output int hc);
        bit got;
        send(r, wr, a, d, 40, got, hc);
        chk("handshake", 32'(got), 32'(1));
    endtask

    task automatic wait_rsp(input int n);
        int k = 0;
        while (rq_data.size() < n && k < 100) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk("rsp_arrived", 32'(rq_data.size() >= n), 32'(1));
    endtask

    task automatic do_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int h0, h1, h2, h3, base;
        do_reset();

        for (int i = 0; i < 16; i++) dsend(0, 1'b1, 12'(i), 14'(i * 16), h0);

        // Writes then read-sum: R1+R2+R3
        dsend(0, 1'b1, 12'h001, 14'h0005, h0);
        dsend(0, 1'b1, 12'h002, 14'h0010, h0);
        dsend(0, 1'b1, 12'h003, 14'h0100, h0);
        base = rq_data.size();
        dsend(0, 1'b0, 12'h123, 14'h0, h0);
        wait_rsp(base + 1);
        chk("sum_basic", 32'(rq_data[base]), 32'h0115);
        chk("sum_basic_id", 32'(rq_id[base]), 32'(0));

        // Wrap-around of the sum
        dsend(0, 1'b1, 12'h003, 14'h3FF0, h0);
        dsend(0, 1'b1, 12'h001, 14'h0005, h0);
        dsend(0, 1'b1, 12'h002, 14'h0010, h0);
        base = rq_data.size();
        dsend(0, 1'b0, 12'h123, 14'h0, h0);
        wait_rsp(base + 1);
        chk("sum_wrap", 32'(rq_data[base]), 32'h0005);

        // Contention from reset, then back-to-back alternation
        do_reset();
        base = rq_data.size();
        fork
            dsend(0, 1'b0, 12'h111, 14'h0, h0);
            dsend(1, 1'b0, 12'h222, 14'h0, h1);
        join
        chk("contend_gap", 32'(h1 - h0), 32'(5));
        wait_rsp(base + 2);
        chk("contend_id0", 32'(rq_id[base]), 32'(0));
        chk("contend_id1", 32'(rq_id[base + 1]), 32'(1));
        chk("contend_sum0", 32'(rq_data[base]), 32'h000F);
        base = rq_data.size();
        fork
            begin dsend(0, 1'b0, 12'h111, 14'h0, h0); dsend(0, 1'b0, 12'h111, 14'h0, h2); end
            begin dsend(1, 1'b0, 12'h222, 14'h0, h1); dsend(1, 1'b0, 12'h222, 14'h0, h3); end
        join
        wait_rsp(base + 4);
        for (int i = 0; i < 4; i++) chk("alternate_id", 32'(rq_id[base + i]), 32'(i % 2));

        // Reset in the middle of a read
        base = rq_data.size();
        dsend(0, 1'b0, 12'h123, 14'h0, h0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_raddr", 32'(rf_raddr), 32'(0));
        chk("rst_rsp", 32'({rsp_valid, rsp_id, rsp_data}), 32'(0));
        chk("rst_wr", 32'({rf_we, rf_waddr, rf_wdata}), 32'(0));
        chk("rst_ready", 32'({req0_ready, req1_ready}), 32'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("rst_no_rsp", 32'(rq_data.size()), 32'(base));
        fork
            dsend(0, 1'b0, 12'h111, 14'h0, h0);
            dsend(1, 1'b0, 12'h222, 14'h0, h1);
        join
        chk("rst_regrant", 32'(h0 < h1), 32'(1));
        wait_rsp(base + 2);

        // Write contending with a read; preset R4 = 0x40
        do_reset();
        base = rq_data.size();
        fork
            dsend(1, 1'b1, 12'h004, 14'h1234, h1);
            dsend(0, 1'b0, 12'h444, 14'h0, h0);
        join
        chk("mixed_order", 32'(h1 - h0), 32'(5));
        wait_rsp(base + 1);
        chk("mixed_old", 32'(rq_data[base]), 32'h00C0);
        dsend(0, 1'b0, 12'h444, 14'h0, h0);
        wait_rsp(base + 2);
        chk("mixed_new", 32'(rq_data[base + 1]), 32'h369C);

        // Requester 1 waits out a whole read
        dsend(0, 1'b0, 12'h123, 14'h0, h0);
        dsend(1, 1'b1, 12'h005, 14'h0ABC, h1);
        chk("busy_gap", 32'(h1 - h0), 32'(5));

        // Random traffic, including requests withdrawn before acceptance
        fork
            for (int n = 0; n < 50; n++) begin
                bit got; int hc;
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                send(0, 1'($urandom), 12'($urandom), 14'($urandom),
                     ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 40, got, hc);
            end
            for (int n = 0; n < 50; n++) begin
                bit got; int hc;
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                send(1, 1'($urandom), 12'($urandom), 14'($urandom),
                     ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 40, got, hc);
            end
        join
        repeat (10) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gpr_access_ctrl.md
Name: gpr_access_ctrl

Overview:
- Sequencer and arbiter in front of the general-purpose register file (16 x 14-bit, one read port, one write port).
- Shares the file between two requesters (req0, req1) with round-robin arbitration.
- Executes single-register writes.
- Executes three-operand "read-sum" commands: three register reads over the single read port, summed, returned as one response.
- Replaces the combinational 3-way read-add with a timed, multi-cycle access.

Parameters:
- DATA_W, 14, register data width.
- ADDR_W, 12, command address width; carries three REG_W-bit register index fields.
- REG_W, 4, register index width (2^REG_W registers); ADDR_W >= 3*REG_W required.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 command valid.
- req0_ready  out  1  requester 0 command accepted this cycle.
- req0_wr  in  1  1 = write, 0 = read-sum.
- req0_addr  in  ADDR_W  write: index in [REG_W-1:0]; read: idx A=[ADDR_W-1:ADDR_W-REG_W], B=next REG_W bits down, C=next REG_W bits down.
- req0_wdata  in  DATA_W  write data.
- req1_valid, req1_ready, req1_wr, req1_addr, req1_wdata  as req0, for requester 1.
- rsp_valid  out  1  one-cycle read-sum result pulse.
- rsp_id  out  1  requester that issued the read.
- rsp_data  out  DATA_W  sum result.
- rf_raddr  out  REG_W  register file read index; rf_rdata is combinational from it.
- rf_rdata  in  DATA_W  register file read data.
- rf_we  out  1  register file write enable.
- rf_waddr  out  REG_W  write index.
- rf_wdata  out  DATA_W  write data.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all outputs 0; acc=0; last_grant=1 (req0 wins first contention).
  - Reset mid-operation aborts: no rf_we, no rsp_valid after release.
- States: IDLE, WR, RD_A, RD_B, RD_C, RESP.
- IDLE:
  - grant = single valid requester; if both valid, requester != last_grant.
  - reqN_ready = (state==IDLE) & grantN, combinational; never both high.
  - On handshake (valid & ready): latch wr, addr, wdata, id; last_grant <= id.
  - Next state: WR if wr, else RD_A.
- WR (1 cycle): rf_we=1, rf_waddr=addr[REG_W-1:0], rf_wdata=latched wdata; next IDLE.
  - Write handshake at cycle T gives rf_we at T+1.
- RD_A: rf_raddr=A; acc <= rf_rdata.
- RD_B: rf_raddr=B; acc <= acc + rf_rdata.
- RD_C: rf_raddr=C; acc <= acc + rf_rdata.
- Sum is modulo 2^DATA_W; carries discarded; no overflow flag.
- RESP: rsp_valid=1, rsp_data=acc, rsp_id=latched id, for exactly one cycle; next IDLE.
  - Read handshake at T gives rsp_valid at T+4.
  - No response backpressure; requester must sample.
- Outside RESP: rsp_valid=0; rsp_data/rsp_id hold last value.
- Outside WR: rf_we=0.
- Outside RD_*: rf_raddr holds last value.
- Throughput:
  - Next handshake possible at T+2 after a write, T+5 after a read.
  - Requests are not accepted while busy=1; requesters hold valid and payload until ready.
- Repeated indices (e.g. A=B=C) are legal and read the same register three times.
- Ordering: a write accepted before a read is visible to that read, since the write completes before the next grant.
- Requester valid dropping before ready is legal; no command is latched.

Test Plan:
1. Writes + read-sum: req0 writes R1=0x0005, R2=0x0010, R3=0x0100, then reads addr=0x123 -> rf_we at T+1 for each write; rsp_valid at T+4 with rsp_data=0x0115, rsp_id=0.
2. Wrap-around: R3=0x3FF0, R1=0x0005, R2=0x0010, read 0x123 -> rsp_data=0x0005 (0x4005 mod 2^14).
3. Contention: req0 and req1 hold valid (reads 0x111 and 0x222) from reset -> req0 granted first, req1 at T+5; rsp_id sequence 0,1; ready never both high. With both holding back-to-back, grants alternate 0,1,0,1.
4. Reset mid-read: assert rst_n=0 while in RD_B -> outputs 0 immediately; no rsp_valid after release; next contention grants req0.
5. Mixed: req1 write R4=0x1234 contends with req0 read 0x444 -> req0 read first returns old 3*R4. Then req1 write. A re-issued read returns 0x369C (3*0x1234 mod 2^14).
6. Busy backpressure: req1_valid asserted during a read sequence -> req1_ready stays 0 until IDLE; accepted on the cycle after RESP.
